// File: rtl/word_fifo.sv
// Word FIFO for completed serial words: registered pointers with one extra wrap bit,
// combinational head read that is zeroed while the FIFO is empty.
module word_fifo #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [width-1:0] mem_q [depth];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end
endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel converter: assembles LSB-first serial bits into width-bit words
// and queues completed words in a small FIFO with valid/ready output.
module serial_to_parallel #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    input  logic             flush,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             overflow
);
    localparam int CW = $clog2(width);

    logic [CW-1:0]    count_q;
    logic [width-1:0] asm_q;
    logic [width-1:0] word_d;
    logic             overflow_q;
    logic             last_bit;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;

    // Word as it would look with this cycle's bit placed; used both to update and to push.
    always_comb begin
        word_d          = asm_q;
        word_d[count_q] = serial_data;
    end

    assign last_bit = (count_q == CW'(width - 1));
    assign push     = serial_valid && !flush && last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            asm_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (flush) begin
                count_q <= '0;
                asm_q   <= '0;
            end else if (serial_valid) begin
                if (last_bit) begin
                    count_q <= '0;
                    asm_q   <= '0;
                end else begin
                    count_q <= count_q + CW'(1);
                    asm_q   <= word_d;
                end
            end
            // A full FIFO is never empty, so a simultaneous pop happens exactly when out_ready is high.
            overflow_q <= push && fifo_full && !out_ready;
        end
    end

    word_fifo #(
        .width (width),
        .depth (depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word_d),
        .pop       (out_ready),
        .head_data (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy      = (count_q != '0);
    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: directed scenarios plus random traffic, all checked
// every cycle against a queue-based word model.
module tb_serial_to_parallel;
    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_valid = 1'b0;
    logic         serial_data = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         overflow;

    int vectors = 0;
    int errors  = 0;

    // Reference model: number of bits held, partial word, and the FIFO as a queue of words.
    int           m_bits = 0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] m_q[$];
    logic         m_ovf = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] deliv_q[$];

    serial_to_parallel #(.width(W), .depth(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_valid (serial_valid),
        .serial_data  (serial_data),
        .flush        (flush),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs; model advances, then DUT is checked.
    task automatic tick();
        logic         done;
        logic [W-1:0] w;
        logic         popped;
        done = 1'b0;
        w    = '0;
        if (!rst && out_valid === 1'b1 && out_ready) deliv_q.push_back(out_data);
        if (rst) begin
            m_bits = 0;
            m_acc  = '0;
            m_q.delete();
            m_ovf  = 1'b0;
        end else begin
            popped = (m_q.size() > 0) && out_ready;
            if (flush) begin
                m_bits = 0;
                m_acc  = '0;
            end else if (serial_valid) begin
                m_acc  = m_acc | (W'(serial_data) << m_bits);
                m_bits = m_bits + 1;
                if (m_bits == W) begin
                    done   = 1'b1;
                    w      = m_acc;
                    m_bits = 0;
                    m_acc  = '0;
                end
            end
            m_ovf = 1'b0;
            if (popped) void'(m_q.pop_front());
            if (done) begin
                if (m_q.size() < D) m_q.push_back(w);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_bits != 0));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        chk("out_data", 32'(out_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        serial_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int nbits, input int max_gap);
        for (int i = 0; i < nbits; i++) begin
            serial_valid = 1'b1;
            serial_data  = word[i];
            tick();
            serial_valid = 1'b0;
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
        end
    endtask

    task automatic check_deliv(input string tag);
        chk({tag, "_count"}, 32'(deliv_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < deliv_q.size()) chk({tag, "_word"}, 32'(deliv_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        deliv_q.delete();
    endtask

    initial begin
        logic [W-1:0] lw;

        // Reset state, with inputs toggling that must be ignored.
        rst = 1'b1;
        serial_valid = 1'b1;
        serial_data = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        serial_valid = 1'b0;
        out_ready = 1'b1;
        idle(1);
        deliv_q.delete();

        // Contiguous 0xA5 with consumer always ready.
        send_bits(8'hA5, W, 0);
        idle(3);
        exp_q.push_back(8'hA5);
        check_deliv("a5_contig");

        // 0x3C with random 0..3 idle gaps between bits.
        send_bits(8'h3C, W, 3);
        idle(3);
        exp_q.push_back(8'h3C);
        check_deliv("3c_gaps");

        // Consumer stalled: third word is dropped.
        out_ready = 1'b0;
        send_bits(8'h11, W, 0);
        send_bits(8'h22, W, 0);
        send_bits(8'h33, W, 0);
        idle(3);
        out_ready = 1'b1;
        idle(4);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        check_deliv("overflow_drop");

        // Full FIFO but a pop coincides with the completing bit: nothing is dropped.
        out_ready = 1'b0;
        send_bits(8'h11, W, 0);
        send_bits(8'h22, W, 0);
        lw = 8'h33;
        send_bits(lw, W - 1, 0);
        out_ready = 1'b1;
        serial_valid = 1'b1;
        serial_data = lw[W-1];
        tick();
        idle(4);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        check_deliv("full_push_pop");

        // Flush after three bits, with a competing valid bit that must be discarded.
        send_bits(8'h07, 3, 0);
        flush = 1'b1;
        serial_valid = 1'b1;
        serial_data = 1'b1;
        tick();
        flush = 1'b0;
        send_bits(8'h5A, W, 0);
        idle(3);
        exp_q.push_back(8'h5A);
        check_deliv("flush");

        // Reset mid-word with two stored words, then a fresh word.
        out_ready = 1'b0;
        send_bits(8'h12, W, 0);
        send_bits(8'h34, W, 0);
        send_bits(8'h0F, 4, 0);
        rst = 1'b1;
        serial_valid = 1'b1;
        tick();
        rst = 1'b0;
        serial_valid = 1'b0;
        out_ready = 1'b1;
        idle(1);
        deliv_q.delete();
        send_bits(8'hFF, W, 0);
        idle(3);
        exp_q.push_back(8'hFF);
        check_deliv("reset_mid");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            serial_valid = ($urandom_range(3, 0) != 0);
            serial_data  = 1'($urandom);
            flush        = ($urandom_range(40, 0) == 0);
            out_ready    = ($urandom_range(2, 0) != 0);
            rst          = ($urandom_range(150, 0) == 0);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the number of serial bits per output word (at least 2).
REQ-002 The block SHALL have parameter depth, default 2, giving the output word FIFO entries (a power of 2, at least 2).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port serial_valid, input, 1 bit: serial_data carries a bit this cycle.
REQ-007 The block SHALL have port serial_data, input, 1 bit: the serial bit, LSB of each word first.
REQ-008 The block SHALL have port flush, input, 1 bit: discard the partially assembled word.
REQ-009 The block SHALL have port busy, output, 1 bit: a partial word is in progress (1 to width-1 bits collected).
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a complete word (FIFO not empty).
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data when out_valid is also high.
REQ-012 The block SHALL have port out_data, output, width bits: the oldest complete word.
REQ-013 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-014 The bit counter SHALL count 0..width-1; count 0 is IDLE and any non-zero count is COLLECTING; busy SHALL be high whenever the count is non-zero.
REQ-015 Each cycle with serial_valid=1 SHALL store serial_data at bit position count of the assembly register and increment count.
REQ-016 Cycles with serial_valid=0 SHALL hold the count and the assembly register; gaps of any length SHALL be allowed between bits.
REQ-017 The bit accepted at count=width-1 SHALL complete the word, return the count to 0, and push the assembled word (including that bit) into the FIFO.
REQ-018 A completed word SHALL appear on out_data with out_valid=1 no earlier than the cycle after its last bit (1-cycle latency when the FIFO was empty).
REQ-019 A pop SHALL occur on each cycle with out_valid=1 and out_ready=1; out_data and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 Words SHALL leave the FIFO in arrival order; out_data SHALL be 0 when out_valid=0.
REQ-021 A push and a pop in the same cycle SHALL both succeed at any occupancy, including a full FIFO.
REQ-022 A push to a full FIFO with no simultaneous pop SHALL drop the new word, leave the FIFO contents unchanged, and pulse overflow high in the following cycle for exactly one cycle.
REQ-023 flush=1 SHALL return the count to 0 and clear the assembly register, and SHALL take priority over a serial_valid bit in the same cycle, which is discarded.
REQ-024 flush SHALL NOT affect words already in the FIFO.
REQ-025 The FIFO read and write pointers SHALL wrap modulo depth, with full and empty distinguished by an extra pointer bit.

Reset
REQ-026 While rst=1 the block SHALL clear the count to 0, the assembly register to 0 and both FIFO pointers to 0, and SHALL ignore all inputs.
REQ-027 In the cycle after rst is sampled high, busy, out_valid, overflow and out_data SHALL all be 0.
REQ-028 A reset during COLLECTING, or with words held in the FIFO, SHALL discard the partial word and all stored words.

Structure
REQ-029 No shared package SHALL be used; width and depth SHALL be module parameters, and pointer widths SHALL be derived as $clog2(depth)+1.
REQ-030 The FIFO SHALL be one sub-module, word_fifo (parameters width and depth, push/pop interface, full/empty flags); the bit counter and assembly register SHALL stay in the top module.

Verification
REQ-031 With width=8 and out_ready=1, 8 contiguous bits of 0xA5 (LSB first) SHALL give out_valid=1 and out_data=0xA5 for one cycle, the cycle after the 8th bit; busy SHALL be high from bit 2 through bit 8.
REQ-032 The bits of 0x3C with 0 to 3 idle cycles between bits SHALL give out_data=0x3C once, with busy held high across the gaps.
REQ-033 With out_ready=0, words 0x11, 0x22 and 0x33 SHALL give an overflow pulse the cycle after 0x33 completes; raising out_ready SHALL then deliver 0x11 followed by 0x22 only.
REQ-034 With the FIFO full of 0x11 and 0x22, and out_ready=1 in the cycle 0x33 completes, overflow SHALL stay 0 and 0x11, 0x22, 0x33 SHALL be delivered in order.
REQ-035 Three bits, then flush, then 8 bits of 0x5A SHALL produce only the word 0x5A.
REQ-036 rst=1 asserted after 4 bits with 2 words stored SHALL give out_valid=0 and busy=0 the next cycle; a following 8-bit word 0xFF SHALL give out_data=0xFF.
